fir_hs_driver: RTL and testbench
================================

Name: fir_hs_driver

Overview:
- Initiator side of the ap_ctrl_hs block-level handshake used by the HLS-generated fir core.
- Takes 8-bit samples from an upstream valid/ready stream and issues one ap_start transaction per sample, holding x stable.
- Captures y on y_ap_vld and returns results downstream over a valid/ready stream.
- Sits between the sample source and the fir instance so that fir can be used without a SystemC testbench driving it.

Parameters:
- IN_DEPTH, 4, input sample FIFO entries (power of two, >=2)
- OUT_DEPTH, 4, output result FIFO entries (power of two, >=2)
- TIMEOUT, 64, max cycles per transaction before abort; 0 disables the watchdog

Ports:
- ap_clk  in  1  clock, rising edge
- ap_rst  in  1  synchronous active-high reset
- in_valid  in  1  upstream sample valid
- in_ready  out  1  input FIFO not full
- in_data  in  8  upstream sample
- out_valid  out  1  output FIFO not empty
- out_ready  in  1  downstream accept
- out_data  out  16  head of output FIFO
- ap_start  out  1  to fir
- x  out  8  to fir, operand
- ap_done  in  1  from fir
- ap_idle  in  1  from fir (status only)
- ap_ready  in  1  from fir
- y  in  16  from fir
- y_ap_vld  in  1  from fir, y qualifier
- txn_count  out  16  completed transactions, wraps at 0xFFFF->0
- timeout_err  out  1  sticky watchdog abort flag
- protocol_err  out  1  sticky: y_ap_vld or ap_done while no transaction outstanding

Behaviour:
- Clock and reset: one clock (ap_clk); ap_rst is synchronous and active-high. All registers are sampled on the ap_clk rising edge.
- Reset values: FIFOs empty; ap_start=0; x=0; out_valid=0; txn_count=0; both error flags=0; state IDLE.
  - in_ready=0 while ap_rst=1, and 1 from the first cycle after reset.
- Reset mid-transaction: ap_start=0 the cycle after ap_rst is sampled high; all queued samples and results are discarded.
- Input FIFO: push when in_valid&&in_ready. in_ready=!full.
- Output FIFO: pop when out_valid&&out_ready. out_data is valid whenever out_valid=1.
- Output FIFO simultaneous push and pop: allowed when full; count is unchanged.
- At most one transaction is in flight.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - Go to ISSUE when the input FIFO is non-empty AND output FIFO count < OUT_DEPTH.
  - Reserving the output slot is required because fir cannot be back-pressured.
  - On the transition, pop the input head into x; ap_start=1 from the next cycle.
  - A sample pushed into an empty FIFO can start at the earliest 1 cycle after the push.
- ISSUE:
  - ap_start=1; x held constant.
  - On ap_ready=1: ap_start=0 next cycle.
  - If the result has already been captured (in this or an earlier cycle) go to IDLE, otherwise go to WAIT.
- WAIT:
  - ap_start=0, x held.
  - On y_ap_vld=1: push y into the output FIFO and go to IDLE.
- Result capture:
  - y_ap_vld in ISSUE or WAIT pushes y exactly once per transaction; a second y_ap_vld in the same transaction is ignored and sets protocol_err.
  - ap_done has no effect on the FSM.
- Transaction completion:
  - A transaction completes when ap_ready has been seen and y has been captured, in either order or in the same cycle.
  - txn_count increments in the completion cycle.
- Protocol errors:
  - y_ap_vld=1 or ap_done=1 in IDLE sets protocol_err.
  - That y is not pushed.
- Watchdog:
  - A cycle counter clears on entry to ISSUE.
  - When TIMEOUT!=0 and the count reaches TIMEOUT in ISSUE/WAIT: set timeout_err, ap_start=0 next cycle, discard the sample, no result pushed, go to IDLE.
  - The reserved output slot is released.
  - txn_count is not incremented.
- Error flags clear only on ap_rst.
- Throughput: minimum 2 cycles per sample (IDLE, ISSUE with ap_ready and y_ap_vld both in the first ISSUE cycle).
- Ordering: outputs leave in input order.

Test Plan:
- Reset values:
  - Stimulus: hold ap_rst 3 cycles, release.
  - Required: ap_start=0, x=0, out_valid=0, txn_count=0, both errors 0; in_ready=0 during reset, 1 after.
- Single sample, delayed core response:
  - Stimulus: push in_data=0x03; core model raises ap_ready 2 cycles after ap_start, then y_ap_vld with y=0x1234 1 cycle later.
  - Required: ap_start high exactly until ap_ready, x=0x03 throughout, out_data=0x1234 with out_valid, txn_count=1.
- Same-cycle completion:
  - Stimulus: core asserts ap_ready and y_ap_vld in the first ISSUE cycle; stream 5 samples 1..5 with y=x*2.
  - Required: outputs 2,4,6,8,10 in order, 2 cycles per sample, txn_count=5.
- Backpressure:
  - Stimulus: out_ready=0, offer 10 samples.
  - Required:
    - exactly 4 results buffered; ap_start is not raised for the 5th sample;
    - in_ready drops once the input FIFO holds 4;
    - release out_ready: all 8 accepted samples emerge in order.
- Watchdog:
  - Stimulus: TIMEOUT=16, core never asserts ap_ready.
  - Required: ap_start falls after 16 ISSUE cycles; timeout_err=1; no output pushed; the next sample proceeds normally.
- Spurious responses:
  - Stimulus: pulse y_ap_vld in IDLE.
  - Required: protocol_err=1, output FIFO unchanged.
  - Stimulus: assert ap_rst in WAIT.
  - Required: ap_start=0, FIFOs empty, errors cleared on the next cycle.

Source files
------------

// File: rtl/fir_hs_driver.sv
`default_nettype none
// ============================================================================
//  Module   : fir_hs_driver
//  Purpose  : ap_ctrl_hs initiator for the HLS fir core. Buffers input
//             samples, issues one ap_start transaction per sample, captures
//             y on y_ap_vld and streams results out in input order.
//  Revision : 1.0  initial release
// ============================================================================
module fir_hs_driver #(
  parameter int IN_DEPTH  = 4,
  parameter int OUT_DEPTH = 4,
  parameter int TIMEOUT   = 64
) (
  input  logic        ap_clk,
  input  logic        ap_rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        ap_start,
  output logic [7:0]  x,
  input  logic        ap_done,
  input  logic        ap_idle,
  input  logic        ap_ready,
  input  logic [15:0] y,
  input  logic        y_ap_vld,
  output logic [15:0] txn_count,
  output logic        timeout_err,
  output logic        protocol_err
);

  localparam int IN_AW   = $clog2(IN_DEPTH);
  localparam int IN_CW   = IN_AW + 1;
  localparam int OUT_AW  = $clog2(OUT_DEPTH);
  localparam int OUT_CW  = OUT_AW + 1;
  localparam int WD_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_t;

  state_t              state_q, state_d;
  logic [7:0]          x_q, x_d;
  logic                got_y_q, got_y_d;
  logic [WD_W-1:0]     wd_q, wd_d;
  logic [15:0]         txn_q, txn_d;
  logic                terr_q, terr_d;
  logic                perr_q, perr_d;

  logic [7:0]          in_mem_q [IN_DEPTH];
  logic [IN_AW-1:0]    in_wr_q, in_wr_d, in_rd_q, in_rd_d;
  logic [IN_CW-1:0]    in_cnt_q, in_cnt_d;
  logic [15:0]         out_mem_q [OUT_DEPTH];
  logic [OUT_AW-1:0]   out_wr_q, out_wr_d, out_rd_q, out_rd_d;
  logic [OUT_CW-1:0]   out_cnt_q, out_cnt_d;

  logic in_push, in_pop, out_push, out_pop, capture, wd_hit;

  // ap_idle is status only; the handshake never depends on it
  logic unused_idle;
  assign unused_idle = ap_idle;

  assign in_ready     = (in_cnt_q != IN_CW'(IN_DEPTH)) && !ap_rst;
  assign in_push      = in_valid && in_ready;
  assign out_valid    = (out_cnt_q != '0);
  assign out_pop      = out_valid && out_ready;
  assign out_data     = out_mem_q[out_rd_q];
  assign ap_start     = (state_q == ISSUE);
  assign x            = x_q;
  assign txn_count    = txn_q;
  assign timeout_err  = terr_q;
  assign protocol_err = perr_q;
  assign wd_hit       = (TIMEOUT != 0) && (wd_q == WD_W'(TO_LAST));

  // Handshake FSM: one transaction in flight, output slot reserved at issue
  // so a result from the non-stallable core always has somewhere to land
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    got_y_d  = got_y_q;
    wd_d     = wd_q;
    txn_d    = txn_q;
    terr_d   = terr_q;
    perr_d   = perr_q;
    in_pop   = 1'b0;
    out_push = 1'b0;
    capture  = 1'b0;
    case (state_q)
      IDLE: begin
        if (y_ap_vld || ap_done) perr_d = 1'b1;
        if ((in_cnt_q != '0) && (out_cnt_q < OUT_CW'(OUT_DEPTH))) begin
          in_pop  = 1'b1;
          x_d     = in_mem_q[in_rd_q];
          got_y_d = 1'b0;
          wd_d    = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        capture = y_ap_vld && !got_y_q;
        if (y_ap_vld && got_y_q) perr_d = 1'b1;
        if (ap_ready && (got_y_q || capture)) begin
          out_push = capture;
          txn_d    = txn_q + 16'd1;
          state_d  = IDLE;
        end else if (wd_hit) begin
          // abort: sample dropped, any y arriving now is not kept
          terr_d  = 1'b1;
          state_d = IDLE;
        end else begin
          out_push = capture;
          if (capture) got_y_d = 1'b1;
          if (ap_ready) state_d = WAIT;
          wd_d = wd_q + WD_W'(1);
        end
      end
      WAIT: begin
        // ap_ready already seen and y not yet captured
        if (y_ap_vld) begin
          out_push = 1'b1;
          txn_d    = txn_q + 16'd1;
          state_d  = IDLE;
        end else if (wd_hit) begin
          terr_d  = 1'b1;
          state_d = IDLE;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Input FIFO pointer and occupancy update
  always_comb begin
    in_wr_d  = in_wr_q;
    in_rd_d  = in_rd_q;
    in_cnt_d = in_cnt_q;
    if (in_push) in_wr_d = in_wr_q + IN_AW'(1);
    if (in_pop)  in_rd_d = in_rd_q + IN_AW'(1);
    case ({in_push, in_pop})
      2'b10:   in_cnt_d = in_cnt_q + IN_CW'(1);
      2'b01:   in_cnt_d = in_cnt_q - IN_CW'(1);
      default: in_cnt_d = in_cnt_q;
    endcase
  end

  // Output FIFO pointer and occupancy update; push+pop keeps count
  always_comb begin
    out_wr_d  = out_wr_q;
    out_rd_d  = out_rd_q;
    out_cnt_d = out_cnt_q;
    if (out_push) out_wr_d = out_wr_q + OUT_AW'(1);
    if (out_pop)  out_rd_d = out_rd_q + OUT_AW'(1);
    case ({out_push, out_pop})
      2'b10:   out_cnt_d = out_cnt_q + OUT_CW'(1);
      2'b01:   out_cnt_d = out_cnt_q - OUT_CW'(1);
      default: out_cnt_d = out_cnt_q;
    endcase
  end

  // Control and pointer registers, synchronous reset discards everything
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q   <= IDLE;
      x_q       <= '0;
      got_y_q   <= 1'b0;
      wd_q      <= '0;
      txn_q     <= '0;
      terr_q    <= 1'b0;
      perr_q    <= 1'b0;
      in_wr_q   <= '0;
      in_rd_q   <= '0;
      in_cnt_q  <= '0;
      out_wr_q  <= '0;
      out_rd_q  <= '0;
      out_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      got_y_q   <= got_y_d;
      wd_q      <= wd_d;
      txn_q     <= txn_d;
      terr_q    <= terr_d;
      perr_q    <= perr_d;
      in_wr_q   <= in_wr_d;
      in_rd_q   <= in_rd_d;
      in_cnt_q  <= in_cnt_d;
      out_wr_q  <= out_wr_d;
      out_rd_q  <= out_rd_d;
      out_cnt_q <= out_cnt_d;
    end
  end

  // FIFO storage, contents are don't-care until the pointers cover them
  always_ff @(posedge ap_clk) begin
    if (in_push)  in_mem_q[in_wr_q]   <= in_data;
    if (out_push) out_mem_q[out_wr_q] <= y;
  end

endmodule
`default_nettype wire

// File: tb/tb_fir_hs_driver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fir_hs_driver
//  Purpose  : Directed self-checking bench for fir_hs_driver with a small
//             behavioural fir core responder.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fir_hs_driver;

  logic        ap_clk = 1'b0;
  logic        ap_rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        ap_start;
  logic [7:0]  x;
  logic        ap_done;
  logic        ap_idle;
  logic        ap_ready;
  logic [15:0] y;
  logic        y_ap_vld;
  logic [15:0] txn_count;
  logic        timeout_err;
  logic        protocol_err;

  // core model outputs and bench-injected spurious pulses
  logic        m_rdy, m_vld;
  logic [15:0] m_y;
  logic        spur_vld, spur_done;
  logic [15:0] spur_y;
  int          core_mode;
  int          m_hi;
  logic        m_pend;

  assign ap_ready = m_rdy;
  assign y_ap_vld = m_vld | spur_vld;
  assign y        = spur_vld ? spur_y : m_y;
  assign ap_done  = m_vld | spur_done;
  assign ap_idle  = ~ap_start;

  fir_hs_driver #(.IN_DEPTH(4), .OUT_DEPTH(4), .TIMEOUT(16)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .ap_start(ap_start), .x(x), .ap_done(ap_done), .ap_idle(ap_idle),
    .ap_ready(ap_ready), .y(y), .y_ap_vld(y_ap_vld),
    .txn_count(txn_count), .timeout_err(timeout_err), .protocol_err(protocol_err)
  );

  always #5 ap_clk = ~ap_clk;

  // Core model: 0 silent, 1 ready 2 cycles after start then y=0x1234,
  // 2 ready+y in first start cycle with y=2*x, 3 ready only (never y)
  initial begin
    m_rdy = 1'b0; m_vld = 1'b0; m_y = '0; m_hi = 0; m_pend = 1'b0;
    forever begin
      @(negedge ap_clk);
      m_rdy = 1'b0;
      m_vld = 1'b0;
      case (core_mode)
        1: begin
          if (m_pend) begin m_vld = 1'b1; m_y = 16'h1234; m_pend = 1'b0; end
          if (ap_start) begin
            m_hi++;
            if (m_hi == 3) begin m_rdy = 1'b1; m_pend = 1'b1; end
          end else m_hi = 0;
        end
        2: begin
          m_rdy = ap_start;
          m_vld = ap_start;
          m_y   = {8'h00, x} << 1;
        end
        3: m_rdy = ap_start;
        default: begin m_hi = 0; m_pend = 1'b0; end
      endcase
    end
  end

  typedef struct {
    logic [7:0]  din;
    logic [15:0] dout;
  } vec_t;
  vec_t vt [15];

  int   total = 0;
  int   bad   = 0;
  logic rise;
  logic prev_start;
  int   idx_in, idx_out, nst, last, cyc, n, hi, xbad;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(negedge ap_clk);
    rise       = ap_start && !prev_start;
    prev_start = ap_start;
  endtask

  task automatic do_reset();
    ap_rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    spur_vld = 1'b0; spur_done = 1'b0;
    repeat (3) step();
    ap_rst = 1'b0;
    step();
  endtask

  task automatic wait_out(input string nm);
    n = 0;
    while (!out_valid && n < 30) begin step(); n++; end
    chk(nm, out_valid, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: sim time %0t exceeded limit", $time);
    $fatal(1, "bench stalled");
  end

  initial begin
    vt[0]  = '{8'h01, 16'h0002}; vt[1]  = '{8'h02, 16'h0004};
    vt[2]  = '{8'h03, 16'h0006}; vt[3]  = '{8'h04, 16'h0008};
    vt[4]  = '{8'h05, 16'h000A};
    vt[5]  = '{8'h10, 16'h0020}; vt[6]  = '{8'h11, 16'h0022};
    vt[7]  = '{8'h12, 16'h0024}; vt[8]  = '{8'h13, 16'h0026};
    vt[9]  = '{8'h14, 16'h0028}; vt[10] = '{8'h15, 16'h002A};
    vt[11] = '{8'h16, 16'h002C}; vt[12] = '{8'h17, 16'h002E};
    vt[13] = '{8'h18, 16'h0030}; vt[14] = '{8'h19, 16'h0032};

    core_mode = 0; prev_start = 1'b0; rise = 1'b0;
    spur_vld = 1'b0; spur_done = 1'b0; spur_y = '0;
    in_data = '0; in_valid = 1'b0; out_ready = 1'b0; ap_rst = 1'b1;

    // reset values
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_in_ready_low", in_ready, 0);
    end
    chk("rst_ap_start", ap_start, 0);
    chk("rst_x", x, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_txn", txn_count, 0);
    chk("rst_terr", timeout_err, 0);
    chk("rst_perr", protocol_err, 0);
    ap_rst = 1'b0;
    step();
    chk("rst_in_ready_after", in_ready, 1);

    // single sample, delayed core response
    core_mode = 1;
    in_valid = 1'b1; in_data = 8'h03;
    step();
    in_valid = 1'b0;
    n = 0;
    while (!ap_start && n < 20) begin step(); n++; end
    chk("single_start_latency", n, 1);
    hi = 0; xbad = 0;
    while (ap_start && hi < 40) begin
      if (x !== 8'h03) xbad++;
      hi++;
      step();
    end
    chk("single_start_cycles", hi, 3);
    chk("single_x_held", xbad, 0);
    wait_out("single_out_valid");
    chk("single_out_data", out_data, 16'h1234);
    chk("single_txn", txn_count, 1);
    chk("single_x_after", x, 8'h03);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    chk("single_popped", out_valid, 0);

    // same-cycle completion, streaming 5 samples
    do_reset();
    core_mode = 2; out_ready = 1'b1;
    idx_in = 0; idx_out = 0; nst = 0; last = 0; cyc = 0;
    while (idx_out < 5 && cyc < 60) begin
      if (out_valid) begin
        chk("stream_out", out_data, vt[idx_out].dout);
        idx_out++;
      end
      if (rise && nst < 5) begin
        chk("stream_x", x, vt[nst].din);
        if (nst > 0) chk("stream_gap", cyc - last, 2);
        last = cyc;
        nst++;
      end
      in_valid = (idx_in < 5);
      in_data  = in_valid ? vt[idx_in].din : 8'h00;
      if (in_valid && in_ready) idx_in++;
      step();
      cyc++;
    end
    in_valid = 1'b0;
    chk("stream_count", idx_out, 5);
    chk("stream_txn", txn_count, 5);

    // backpressure: 10 offered, 8 accepted, 4 results buffered
    do_reset();
    core_mode = 2; out_ready = 1'b0;
    idx_in = 0; nst = 0;
    for (int c = 0; c < 30; c++) begin
      if (rise) nst++;
      in_valid = (idx_in < 10);
      in_data  = in_valid ? vt[5 + idx_in].din : 8'h00;
      if (in_valid && in_ready) idx_in++;
      step();
    end
    if (rise) nst++;
    in_valid = 1'b0;
    chk("bp_accepted", idx_in, 8);
    chk("bp_starts", nst, 4);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_ap_start", ap_start, 0);
    chk("bp_out_valid", out_valid, 1);
    chk("bp_head", out_data, vt[5].dout);
    chk("bp_txn", txn_count, 4);
    out_ready = 1'b1;
    idx_out = 0; cyc = 0;
    while (idx_out < 8 && cyc < 100) begin
      if (out_valid) begin
        chk("bp_out", out_data, vt[5 + idx_out].dout);
        idx_out++;
      end
      step();
      cyc++;
    end
    chk("bp_drained", idx_out, 8);
    step();
    chk("bp_empty", out_valid, 0);
    chk("bp_txn_final", txn_count, 8);

    // watchdog: core silent
    do_reset();
    core_mode = 0; out_ready = 1'b1;
    in_valid = 1'b1; in_data = 8'h55;
    step();
    in_valid = 1'b0;
    n = 0;
    while (!ap_start && n < 20) begin step(); n++; end
    hi = 0;
    while (ap_start && hi < 40) begin hi++; step(); end
    chk("wd_start_cycles", hi, 16);
    chk("wd_terr", timeout_err, 1);
    repeat (3) step();
    chk("wd_no_output", out_valid, 0);
    chk("wd_txn", txn_count, 0);
    core_mode = 2;
    in_valid = 1'b1; in_data = 8'h21;
    step();
    in_valid = 1'b0;
    wait_out("wd_next_valid");
    chk("wd_next_data", out_data, 16'h0042);
    chk("wd_next_txn", txn_count, 1);
    chk("wd_terr_sticky", timeout_err, 1);

    // spurious y_ap_vld in IDLE
    do_reset();
    core_mode = 2; out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h07;
    step();
    in_valid = 1'b0;
    wait_out("spur_setup_valid");
    core_mode = 0;
    repeat (2) step();
    spur_vld = 1'b1; spur_y = 16'hBEEF;
    step();
    spur_vld = 1'b0;
    chk("spur_perr", protocol_err, 1);
    chk("spur_head", out_data, 16'h000E);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    chk("spur_not_pushed", out_valid, 0);
    chk("spur_txn", txn_count, 1);

    // spurious ap_done in IDLE
    do_reset();
    spur_done = 1'b1;
    step();
    spur_done = 1'b0;
    chk("done_perr", protocol_err, 1);

    // reset while in WAIT discards everything
    core_mode = 3;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 8'h09 + 8'(i);
      step();
    end
    in_valid = 1'b0;
    n = 0;
    while (!ap_start && n < 20) begin step(); n++; end
    step();
    chk("wait_entered", ap_start, 0);
    ap_rst = 1'b1;
    step();
    chk("wrst_ap_start", ap_start, 0);
    chk("wrst_out_valid", out_valid, 0);
    chk("wrst_perr", protocol_err, 0);
    chk("wrst_terr", timeout_err, 0);
    ap_rst = 1'b0;
    core_mode = 2;
    nst = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (rise) nst++;
    end
    chk("wrst_no_starts", nst, 0);
    chk("wrst_out_empty", out_valid, 0);
    chk("wrst_in_ready", in_ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
